// File: rtl/stream_demux_if.sv
// Stream demux bus: one producer port in, two consumer ports out, plus per-channel accept counts.
interface stream_demux_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             select;
  logic             in_ready;
  logic [WIDTH-1:0] out0_data;
  logic [WIDTH-1:0] out1_data;
  logic             out0_valid;
  logic             out1_valid;
  logic             out0_ready;
  logic             out1_ready;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  // Demux side
  modport slave (
    input  in_data, in_valid, select, out0_ready, out1_ready,
    output in_ready, out0_data, out1_data, out0_valid, out1_valid, cnt0, cnt1
  );

  // Producer/consumer side
  modport master (
    output in_data, in_valid, select, out0_ready, out1_ready,
    input  in_ready, out0_data, out1_data, out0_valid, out1_valid, cnt0, cnt1
  );
endinterface

// File: rtl/stream_demux.sv
// Routes one input stream into two independent 2-entry FIFO channels chosen by select,
// counting accepted words per channel.
module stream_demux #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic           clk,
  input  logic           reset,
  stream_demux_if.slave  bus
);

  localparam int unsigned DEPTH = 2;
  localparam int unsigned OCC_W = 2;

  logic [WIDTH-1:0] mem     [2][DEPTH];
  logic [1:0]       wr_ptr;
  logic [1:0]       rd_ptr;
  logic [OCC_W-1:0] occ     [2];
  logic [CNT_W-1:0] cnt     [2];
  logic [1:0]       push;
  logic [1:0]       pop;
  logic [1:0]       out_ready;
  logic             accept;

  assign out_ready = {bus.out1_ready, bus.out0_ready};

  // Ready looks only at the selected channel's occupancy, never at consumer readies.
  assign bus.in_ready = (occ[bus.select] != OCC_W'(DEPTH));
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    push = 2'b00;
    pop  = 2'b00;
    for (int c = 0; c < 2; c++) begin
      push[c] = accept && (bus.select == 1'(c));
      pop[c]  = (occ[c] != '0) && out_ready[c];
    end
  end

  // Control state: pointers, occupancy and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int c = 0; c < 2; c++) begin
        occ[c] <= '0;
        cnt[c] <= '0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (push[c]) begin
          wr_ptr[c] <= ~wr_ptr[c];
          cnt[c]    <= cnt[c] + CNT_W'(1);
        end
        if (pop[c]) begin
          rd_ptr[c] <= ~rd_ptr[c];
        end
        occ[c] <= occ[c] + OCC_W'(push[c]) - OCC_W'(pop[c]);
      end
    end
  end

  // Storage carries no reset; contents are don't-care while a channel is empty.
  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (push[c]) begin
        mem[c][wr_ptr[c]] <= WIDTH'(bus.in_data);
      end
    end
  end

  assign bus.out0_data  = mem[0][rd_ptr[0]];
  assign bus.out1_data  = mem[1][rd_ptr[1]];
  assign bus.out0_valid = (occ[0] != '0);
  assign bus.out1_valid = (occ[1] != '0);
  assign bus.cnt0       = cnt[0];
  assign bus.cnt1       = cnt[1];

endmodule
